// File: rtl/dcache_sram_sched.sv
// -----------------------------------------------------------------------------
// dcache_sram_sched
//
// Shares a single-ported data-cache SRAM among NR_PORTS requesters. After
// reset the block owns the SRAM and sweeps every set to zero. Once the sweep
// is done, requesters are arbitrated. Port 0 (miss handler) has fixed top
// priority. Ports 1..NR_PORTS-1 (cache controllers) share a round-robin
// pointer. A grantee may hold the SRAM across cycles through lock_i.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   req_i          per-port access request
//   lock_i         per-port request to keep the grant next cycle
//   addr_i         per-port byte index
//   we_i           per-port write enable
//   wdata_i        per-port write data
//   gnt_o          one-hot grant, same cycle as the request
//   rvalid_o       one-hot read-data-valid, one cycle after a read grant
//   rdata_o        SRAM read data, broadcast to all ports
//   sram_*         SRAM strobe, write enable, byte index, write/read data
//   init_done_o    high once the post-reset clear sweep has finished
// -----------------------------------------------------------------------------
module dcache_sram_sched #(
    parameter int NR_PORTS    = 4,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 128,
    parameter int NUM_WORDS   = 256,
    parameter int BYTE_OFFSET = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NR_PORTS-1:0]                  req_i,
    input  logic [NR_PORTS-1:0]                  lock_i,
    input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]  addr_i,
    input  logic [NR_PORTS-1:0]                  we_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
    output logic [NR_PORTS-1:0]                  gnt_o,
    output logic [NR_PORTS-1:0]                  rvalid_o,
    output logic [DATA_WIDTH-1:0]                rdata_o,
    output logic                                 sram_req_o,
    output logic                                 sram_we_o,
    output logic [ADDR_WIDTH-1:0]                sram_addr_o,
    output logic [DATA_WIDTH-1:0]                sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]                sram_rdata_i,
    output logic                                 init_done_o
);

    localparam int PW    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int CNT_W = ($clog2(NUM_WORDS) > 8) ? $clog2(NUM_WORDS) : 8;
    localparam logic [CNT_W-1:0] LAST_SET = CNT_W'(NUM_WORDS - 1);

    typedef enum logic {
        INIT,
        ARB
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;
    logic [PW-1:0]         rr_q, rr_d;
    logic                  lock_valid_q, lock_valid_d;
    logic [PW-1:0]         lock_port_q, lock_port_d;
    logic [NR_PORTS-1:0]   rvalid_q;

    logic                  gnt_any;
    logic [PW-1:0]         gnt_idx;
    logic                  rr_hit;
    logic [PW-1:0]         cand;

    // NOTE: every output and next-state variable gets a default before the
    // case statement so no path through the block can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_done_d  = init_done_q;
        rr_d         = rr_q;
        lock_valid_d = 1'b0;
        lock_port_d  = lock_port_q;
        gnt_o        = '0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        gnt_any      = 1'b0;
        gnt_idx      = '0;
        rr_hit       = 1'b0;
        cand         = '0;

        case (state_q)
            INIT: begin
                // Clear sweep: write zero to one set per cycle.
                sram_req_o  = 1'b1;
                sram_we_o   = 1'b1;
                sram_addr_o = ADDR_WIDTH'(cnt_q) << BYTE_OFFSET;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_SET) begin
                    state_d     = ARB;
                    init_done_d = 1'b1;
                end
            end

            ARB: begin
                // A lock only holds while the owner keeps both req and lock up.
                if (lock_valid_q && req_i[lock_port_q] && lock_i[lock_port_q]) begin
                    gnt_any = 1'b1;
                    gnt_idx = lock_port_q;
                end else if (req_i[0]) begin
                    gnt_any = 1'b1;
                    gnt_idx = '0;
                end else begin
                    // Scan ports 1..NR_PORTS-1 starting at the pointer, wrapping
                    // past the last port back to port 1 (port 0 never in ring).
                    for (int k = 0; k < NR_PORTS - 1; k++) begin
                        cand = PW'(((int'(rr_q) - 1 + k) % (NR_PORTS - 1)) + 1);
                        if (!gnt_any && req_i[cand]) begin
                            gnt_any = 1'b1;
                            gnt_idx = cand;
                            rr_hit  = 1'b1;
                        end
                    end
                end

                if (gnt_any) begin
                    gnt_o[gnt_idx] = 1'b1;
                    sram_req_o     = 1'b1;
                    sram_we_o      = we_i[gnt_idx];
                    sram_addr_o    = addr_i[gnt_idx];
                    sram_wdata_o   = wdata_i[gnt_idx];
                    lock_valid_d   = lock_i[gnt_idx];
                    lock_port_d    = gnt_idx;
                end

                // Only round-robin wins move the pointer.
                if (rr_hit) begin
                    rr_d = (gnt_idx == PW'(NR_PORTS - 1)) ? PW'(1) : gnt_idx + 1'b1;
                end
            end

            default: state_d = INIT;
        endcase
    end

    // NOTE: the block holds no data storage, so every register here is
    // control state and all of it is reset; read data comes straight from
    // the SRAM and needs no reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            init_done_q  <= 1'b0;
            rr_q         <= PW'(1);
            lock_valid_q <= 1'b0;
            lock_port_q  <= '0;
            rvalid_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_done_q  <= init_done_d;
            rr_q         <= rr_d;
            lock_valid_q <= lock_valid_d;
            lock_port_q  <= lock_port_d;
            rvalid_q     <= gnt_o & ~we_i;
        end
    end

    assign rvalid_o    = rvalid_q;
    assign rdata_o     = sram_rdata_i;
    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_dcache_sram_sched.sv
// -----------------------------------------------------------------------------
// tb_dcache_sram_sched
//
// Bench for dcache_sram_sched with default parameters. A simple SRAM model
// sits on the SRAM side. A behavioural model of the scheduler, kept in
// integers, predicts every output on each falling clock edge. Directed
// sequences add hand-computed literal expectations: clear sweep length,
// priority/round-robin order, lock hold, read latency, and mid-sweep or
// mid-lock reset.
// -----------------------------------------------------------------------------
module tb_dcache_sram_sched;

    localparam int NP = 4;
    localparam int AW = 12;
    localparam int DW = 128;
    localparam int NW = 256;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NP-1:0]         req, lock, we;
    logic [NP-1:0][AW-1:0] addr;
    logic [NP-1:0][DW-1:0] wdata;
    logic [NP-1:0]         gnt, rvalid;
    logic [DW-1:0]         rdata;
    logic                  sram_req, sram_we;
    logic [AW-1:0]         sram_addr;
    logic [DW-1:0]         sram_wdata, sram_rdata;
    logic                  init_done;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [0:NW-1];

    localparam logic [DW-1:0] D1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1111_2222;
    localparam logic [DW-1:0] D2 = 128'hA5A5_5A5A_F0F0_0F0F_3333_4444_5555_6666;

    dcache_sram_sched #(
        .NR_PORTS   (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW),
        .BYTE_OFFSET(4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .lock_i      (lock),
        .addr_i      (addr),
        .we_i        (we),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .sram_req_o  (sram_req),
        .sram_we_o   (sram_we),
        .sram_addr_o (sram_addr),
        .sram_wdata_o(sram_wdata),
        .sram_rdata_i(sram_rdata),
        .init_done_o (init_done)
    );

    always #5 clk = ~clk;

    // SRAM with one cycle read latency.
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) mem[sram_addr[11:4]] <= sram_wdata;
            else         sram_rdata <= mem[sram_addr[11:4]];
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NP-1:0] onehot(input int p);
        onehot = '0;
        if (p >= 0) onehot[p[1:0]] = 1'b1;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    initial begin : model
        bit            m_sweep, m_done, rrmove;
        int            m_cnt, m_rr, m_lock, m_rd, g, p;
        logic [DW-1:0] m_rdata;
        logic [NP-1:0] e_gnt, e_rv;
        logic          e_req, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        m_sweep = 1'b1; m_done = 1'b0; m_cnt = 0; m_rr = 1; m_lock = -1; m_rd = -1;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_gnt", gnt, '0);
                check("rst_rvalid", rvalid, '0);
                check("rst_done", init_done, '0);
                m_sweep = 1'b1; m_done = 1'b0; m_cnt = 0; m_rr = 1; m_lock = -1; m_rd = -1;
            end else begin
                g = -1; rrmove = 1'b0;
                e_rv = (m_sweep) ? '0 : onehot(m_rd);
                if (m_sweep) begin
                    e_gnt = '0; e_req = 1'b1; e_we = 1'b1;
                    e_addr = AW'(m_cnt * 16); e_wdata = '0;
                end else begin
                    if (m_lock >= 0 && req[m_lock[1:0]] && lock[m_lock[1:0]]) g = m_lock;
                    else if (req[0]) g = 0;
                    else begin
                        for (int k = 0; k < NP - 1; k++) begin
                            p = m_rr + k;
                            if (p > NP - 1) p = p - (NP - 1);
                            if (g < 0 && req[p[1:0]]) begin
                                g = p;
                                rrmove = 1'b1;
                            end
                        end
                    end
                    e_gnt   = onehot(g);
                    e_req   = (g >= 0);
                    e_we    = (g >= 0) ? we[g[1:0]] : 1'b0;
                    e_addr  = (g >= 0) ? addr[g[1:0]] : '0;
                    e_wdata = (g >= 0) ? wdata[g[1:0]] : '0;
                end

                check("gnt", gnt, e_gnt);
                check("rvalid", rvalid, e_rv);
                check("init_done", init_done, m_done);
                check("sram_req", sram_req, e_req);
                check("sram_we", sram_we, e_we);
                if (e_req) check("sram_addr", sram_addr, e_addr);
                if (e_req && e_we) check("sram_wdata", sram_wdata, e_wdata);
                if (!m_sweep && m_rd >= 0) check("rdata", rdata, m_rdata);

                if (m_sweep) begin
                    if (m_cnt == NW - 1) begin
                        m_sweep = 1'b0;
                        m_done  = 1'b1;
                    end
                    m_cnt++;
                    m_rd = -1;
                end else begin
                    if (rrmove) m_rr = (g == NP - 1) ? 1 : g + 1;
                    m_lock = (g >= 0 && lock[g[1:0]]) ? g : -1;
                    if (g >= 0 && !we[g[1:0]]) begin
                        m_rd    = g;
                        m_rdata = mem[addr[g[1:0]][11:4]];
                    end else begin
                        m_rd = -1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drive one cycle of inputs just after the rising edge; optionally change
    // one port's address/data; return at the following falling edge.
    task automatic step(input logic [NP-1:0] r, input logic [NP-1:0] l, input logic [NP-1:0] w,
                        input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        req = r; lock = l; we = w;
        if (p >= 0) begin
            addr[p[1:0]]  = a;
            wdata[p[1:0]] = d;
        end
        @(negedge clk);
        #1;
    endtask

    // Count sweep cycles until init_done rises, bounded.
    task automatic wait_init(output int n);
        n = 0;
        do begin
            @(negedge clk);
            if (!init_done) n++;
        end while (!init_done && n < 1000);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [NP-1:0] rr_seq [5];

    initial begin : stim
        int n;
        req = '0; lock = '0; we = '0;
        addr  = {12'h300, 12'h200, 12'h120, 12'h010};
        wdata = '0;
        #1;
        check("por_gnt", gnt, '0);
        check("por_done", init_done, '0);

        // Sweep with all ports requesting: no grant may appear.
        @(posedge clk); #1;
        req = 4'b1111;
        @(posedge clk); #1;
        rst = 1'b0;
        check("sweep_first_addr", sram_addr, 12'h000);
        wait_init(n);
        check("sweep_len", n, 256);
        check("first_arb_gnt", gnt, 4'b0001);

        // Port 0 wins every cycle, then round-robin 1,2,3,1,2.
        step(4'b1111, '0, '0, -1, '0, '0);
        check("p0_prio_a", gnt, 4'b0001);
        check("p0_rvalid", rvalid, 4'b0001);
        step(4'b1111, '0, '0, -1, '0, '0);
        check("p0_prio_b", gnt, 4'b0001);
        rr_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100};
        foreach (rr_seq[i]) begin
            step(4'b1110, '0, '0, -1, '0, '0);
            check($sformatf("rr_%0d", i), gnt, rr_seq[i]);
        end

        // Lock: port 2 holds the SRAM against port 0 until it drops lock.
        step(4'b0100, 4'b0100, '0, -1, '0, '0);
        check("lock_first", gnt, 4'b0100);
        step(4'b0101, 4'b0100, '0, -1, '0, '0);
        check("lock_hold", gnt, 4'b0100);
        check("lock_rv1", rvalid, 4'b0100);
        step(4'b0101, 4'b0000, '0, -1, '0, '0);
        check("lock_release", gnt, 4'b0001);
        check("lock_rv2", rvalid, 4'b0100);
        step('0, '0, '0, -1, '0, '0);
        check("idle_gnt", gnt, 4'b0000);
        check("p0_rv_after", rvalid, 4'b0001);
        step(4'b1110, '0, '0, -1, '0, '0);
        check("rr_after_lock", gnt, 4'b1000);

        // Write D1 at 0x120, read it back by port 1, write D2 next cycle.
        step(4'b1000, '0, 4'b1000, 3, 12'h120, D1);
        check("wr_gnt", gnt, 4'b1000);
        step(4'b0010, '0, '0, 1, 12'h120, '0);
        check("rd_gnt", gnt, 4'b0010);
        check("rd_no_rv_from_wr", rvalid, 4'b0000);
        step(4'b1000, '0, 4'b1000, 3, 12'h130, D2);
        check("wr2_gnt", gnt, 4'b1000);
        check("rd_rv", rvalid, 4'b0010);
        check("rd_data", rdata, D1);
        step(4'b0100, '0, '0, 2, 12'h130, '0);
        check("wr2_no_rv", rvalid, 4'b0000);
        step('0, '0, '0, -1, '0, '0);
        check("rd2_rv", rvalid, 4'b0100);
        check("rd2_data", rdata, D2);

        // Reset in the middle of the sweep, at set 100.
        @(posedge clk); #1;
        rst = 1'b1; req = 4'b1111;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("sweep_set100", sram_addr, 12'h640);
        rst = 1'b1;
        #1;
        check("mid_sweep_rst_addr", sram_addr, 12'h000);
        check("mid_sweep_rst_done", init_done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_init(n);
        check("sweep_len_restart", n, 256);

        // Reset during a locked read grant.
        step(4'b0010, 4'b0010, '0, 1, 12'h120, '0);
        check("lk2_first", gnt, 4'b0010);
        step(4'b0011, 4'b0010, '0, -1, '0, '0);
        check("lk2_hold", gnt, 4'b0010);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("lock_rst_gnt", gnt, 4'b0000);
        check("lock_rst_rvalid", rvalid, 4'b0000);
        check("lock_rst_done", init_done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; req = '0; lock = '0;
        wait_init(n);
        check("sweep_len_after_lock", n, 256);
        step(4'b0011, 4'b0010, '0, -1, '0, '0);
        check("lock_cleared", gnt, 4'b0001);

        step('0, '0, '0, -1, '0, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
